// File: rtl/pic_rw_sequencer.sv
// pic_rw_sequencer: CPU bus front end for the interrupt controller.
// Runs the ICW1..ICW4 init sequence, registers OCWs, drives read-back.
module pic_rw_sequencer #(
   parameter int DW             = 8,
   parameter bit CASCADE_EN     = 1'b1,
   parameter bit RD_DEFAULT_ISR = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs_n,
   input  logic          wr_n,
   input  logic          rd_n,
   input  logic          a0,
   input  logic [DW-1:0] din,
   input  logic [DW-1:0] irr_in,
   input  logic [DW-1:0] isr_in,
   input  logic [DW-1:0] poll_in,
   output logic [DW-1:0] icw1_q,
   output logic [DW-1:0] icw2_q,
   output logic [DW-1:0] icw3_q,
   output logic [DW-1:0] icw4_q,
   output logic [DW-1:0] imr_q,
   output logic [DW-1:0] ocw3_q,
   output logic [DW-1:0] ocw2_q,
   output logic          ocw2_stb,
   output logic          poll_stb,
   output logic          smm_q,
   output logic          init_done,
   output logic          icw1_stb,
   output logic          bus_err,
   output logic [DW-1:0] dout,
   output logic          dout_oe
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4,
      READY
   } state_t;

   state_t state;
   state_t state_nxt;

   logic wr_q;
   logic rd_q;
   logic wr_ev;
   logic rd_ev;
   logic clash;
   logic icw1_hit;
   logic ld_icw2;
   logic ld_icw3;
   logic ld_icw4;
   logic ld_imr;
   logic ld_ocw2;
   logic ld_ocw3;
   logic err;
   logic rd_sel;
   logic poll_pend;

   // Falling-edge detect: one event per strobe pulse, none on overlap
   assign wr_ev = wr_q & ~wr_n & ~cs_n & rd_n;
   assign rd_ev = rd_q & ~rd_n & ~cs_n & wr_n;
   assign clash = ~cs_n & ~wr_n & ~rd_n & (wr_q | rd_q);

   assign icw1_hit  = wr_ev & ~a0 & din[4];
   assign init_done = (state == READY);

   always_comb begin
      state_nxt = state;
      ld_icw2   = 1'b0;
      ld_icw3   = 1'b0;
      ld_icw4   = 1'b0;
      ld_imr    = 1'b0;
      ld_ocw2   = 1'b0;
      ld_ocw3   = 1'b0;
      err       = clash;
      if (icw1_hit) begin
         state_nxt = WAIT_ICW2;
      end else if (wr_ev) begin
         case (state)
            IDLE: err = 1'b1;
            WAIT_ICW2: begin
               if (a0) begin
                  ld_icw2 = 1'b1;
                  if (CASCADE_EN && !icw1_q[1])
                     state_nxt = WAIT_ICW3;
                  else if (icw1_q[0])
                     state_nxt = WAIT_ICW4;
                  else
                     state_nxt = READY;
               end else begin
                  err = 1'b1;
               end
            end
            WAIT_ICW3: begin
               if (a0) begin
                  ld_icw3   = 1'b1;
                  state_nxt = icw1_q[0] ? WAIT_ICW4 : READY;
               end else begin
                  err = 1'b1;
               end
            end
            WAIT_ICW4: begin
               if (a0) begin
                  ld_icw4   = 1'b1;
                  state_nxt = READY;
               end else begin
                  err = 1'b1;
               end
            end
            READY: begin
               unique case (1'b1)
                  a0:                ld_imr  = 1'b1;
                  !a0 && din[3]:     ld_ocw3 = 1'b1;
                  !a0 && !din[3]:    ld_ocw2 = 1'b1;
               endcase
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         icw1_q    <= '0;
         icw2_q    <= '0;
         icw3_q    <= '0;
         icw4_q    <= '0;
         imr_q     <= '0;
         ocw2_q    <= '0;
         ocw3_q    <= '0;
         smm_q     <= 1'b0;
         icw1_stb  <= 1'b0;
         ocw2_stb  <= 1'b0;
         poll_stb  <= 1'b0;
         bus_err   <= 1'b0;
         dout      <= '0;
         dout_oe   <= 1'b0;
         rd_sel    <= RD_DEFAULT_ISR;
         poll_pend <= 1'b0;
      end else begin
         wr_q     <= wr_n;
         rd_q     <= rd_n;
         icw1_stb <= icw1_hit;
         ocw2_stb <= ld_ocw2;
         poll_stb <= ld_ocw3 & din[2];
         bus_err  <= err;
         dout_oe  <= ~rd_n & ~cs_n;
         if (icw1_hit) begin
            icw1_q    <= din;
            icw2_q    <= '0;
            icw3_q    <= '0;
            icw4_q    <= '0;
            imr_q     <= '0;
            ocw3_q    <= '0;
            smm_q     <= 1'b0;
            poll_pend <= 1'b0;
            rd_sel    <= RD_DEFAULT_ISR;
         end
         if (ld_icw2) icw2_q <= din;
         if (ld_icw3) icw3_q <= din;
         if (ld_icw4) icw4_q <= din;
         if (ld_imr)  imr_q  <= din;
         if (ld_ocw2) ocw2_q <= din;
         if (ld_ocw3) begin
            ocw3_q <= din;
            if (din[1]) rd_sel <= din[0];
            if (din[6:5] == 2'b11)
               smm_q <= 1'b1;
            else if (din[6:5] == 2'b10)
               smm_q <= 1'b0;
            if (din[2]) poll_pend <= 1'b1;
         end
         if (rd_ev) begin
            if (a0) begin
               dout <= imr_q;
            end else if (poll_pend) begin
               dout      <= poll_in;
               poll_pend <= 1'b0;
            end else if (rd_sel) begin
               dout <= isr_in;
            end else begin
               dout <= irr_in;
            end
         end
      end
   end

endmodule

// File: tb/tb_pic_rw_sequencer.sv
// tb_pic_rw_sequencer: vector table, hand sequences and a randomised
// run against a queue-based model of the init/command protocol.
module tb_pic_rw_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cs_n = 1'b1;
   logic       wr_n = 1'b1;
   logic       rd_n = 1'b1;
   logic       a0 = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] irr_in = '0;
   logic [7:0] isr_in = '0;
   logic [7:0] poll_in = '0;

   logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
   logic [7:0] imr_q, ocw3_q, ocw2_q, dout;
   logic       ocw2_stb, poll_stb, smm_q, init_done;
   logic       icw1_stb, bus_err, dout_oe;

   logic [7:0] n_icw1, n_icw2, n_icw3, n_icw4;
   logic [7:0] n_imr, n_ocw3, n_ocw2, n_dout;
   logic       n_ocw2_stb, n_poll_stb, n_smm, n_init;
   logic       n_icw1_stb, n_bus_err, n_dout_oe;

   always #5 clk = ~clk;

   pic_rw_sequencer #(
      .DW(8), .CASCADE_EN(1'b1), .RD_DEFAULT_ISR(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
      .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
      .irr_in(irr_in), .isr_in(isr_in), .poll_in(poll_in),
      .icw1_q(icw1_q), .icw2_q(icw2_q),
      .icw3_q(icw3_q), .icw4_q(icw4_q),
      .imr_q(imr_q), .ocw3_q(ocw3_q), .ocw2_q(ocw2_q),
      .ocw2_stb(ocw2_stb), .poll_stb(poll_stb),
      .smm_q(smm_q), .init_done(init_done),
      .icw1_stb(icw1_stb), .bus_err(bus_err),
      .dout(dout), .dout_oe(dout_oe)
   );

   pic_rw_sequencer #(
      .DW(8), .CASCADE_EN(1'b0), .RD_DEFAULT_ISR(1'b0)
   ) dut_nc (
      .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
      .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .din(din),
      .irr_in(irr_in), .isr_in(isr_in), .poll_in(poll_in),
      .icw1_q(n_icw1), .icw2_q(n_icw2),
      .icw3_q(n_icw3), .icw4_q(n_icw4),
      .imr_q(n_imr), .ocw3_q(n_ocw3), .ocw2_q(n_ocw2),
      .ocw2_stb(n_ocw2_stb), .poll_stb(n_poll_stb),
      .smm_q(n_smm), .init_done(n_init),
      .icw1_stb(n_icw1_stb), .bus_err(n_bus_err),
      .dout(n_dout), .dout_oe(n_dout_oe)
   );

   int n_chk = 0;
   int n_pass = 0;

   // strobes {icw1, ocw2, poll, err} captured right after the event edge
   logic [3:0] s_stb;
   logic       s_oe;
   logic [7:0] s_dout;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      cs_n = 1'b0;
      a0   = a;
      din  = d;
      wr_n = 1'b0;
      tick();
      s_stb = {icw1_stb, ocw2_stb, poll_stb, bus_err};
      wr_n  = 1'b1;
      cs_n  = 1'b1;
      tick();
   endtask

   task automatic rd(input logic a);
      cs_n = 1'b0;
      a0   = a;
      rd_n = 1'b0;
      tick();
      s_stb  = {icw1_stb, ocw2_stb, poll_stb, bus_err};
      s_oe   = dout_oe;
      s_dout = dout;
      rd_n   = 1'b1;
      cs_n   = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      tick();
   endtask

   // ---- reference model: pending ICW slots as a queue ----
   logic [7:0] m_icw [1:4];
   logic [7:0] m_imr, m_ocw2, m_ocw3;
   bit         m_smm, m_isr_sel, m_poll, m_ready;
   int         m_need[$];

   task automatic m_reset();
      for (int i = 1; i <= 4; i++) m_icw[i] = '0;
      m_imr = '0; m_ocw2 = '0; m_ocw3 = '0;
      m_smm = 0; m_isr_sel = 0; m_poll = 0; m_ready = 0;
      m_need.delete();
   endtask

   task automatic m_write(input logic a, input logic [7:0] d,
                          output logic [3:0] stb);
      stb = 4'b0000;
      if (!a && d[4]) begin
         stb = 4'b1000;
         m_icw[1] = d;
         for (int i = 2; i <= 4; i++) m_icw[i] = '0;
         m_imr = '0; m_ocw3 = '0; m_smm = 0;
         m_poll = 0; m_isr_sel = 0; m_ready = 0;
         m_need.delete();
         m_need.push_back(2);
         if (!d[1]) m_need.push_back(3);
         if (d[0])  m_need.push_back(4);
      end else if (m_need.size() != 0) begin
         if (a) begin
            m_icw[m_need.pop_front()] = d;
            if (m_need.size() == 0) m_ready = 1;
         end else begin
            stb = 4'b0001;
         end
      end else if (!m_ready) begin
         stb = 4'b0001;
      end else if (a) begin
         m_imr = d;
      end else if (d[3]) begin
         m_ocw3 = d;
         if (d[1]) m_isr_sel = d[0];
         if (d[6:5] == 2'b11) m_smm = 1;
         if (d[6:5] == 2'b10) m_smm = 0;
         if (d[2]) begin
            m_poll = 1;
            stb = 4'b0010;
         end
      end else begin
         m_ocw2 = d;
         stb = 4'b0100;
      end
   endtask

   function automatic logic [7:0] m_read(input logic a);
      if (a) return m_imr;
      if (m_poll) begin
         m_poll = 0;
         return poll_in;
      end
      return m_isr_sel ? isr_in : irr_in;
   endfunction

   typedef struct {
      bit         rd;
      bit         a;
      logic [7:0] d;
      logic [7:0] irr;
      logic [7:0] isr;
      logic [7:0] poll;
      logic [3:0] stb;
      bit         init;
      bit         smm;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{0, 0, 8'h12, 8'h00, 8'h00, 8'h00, 4'b1000, 0, 0, 8'h00};
      tbl[1]  = '{0, 1, 8'h20, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 0, 8'h00};
      tbl[2]  = '{0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 4'b0000, 1, 0, 8'h00};
      tbl[3]  = '{1, 1, 8'h00, 8'h11, 8'h40, 8'h87, 4'b0000, 1, 0, 8'hA5};
      tbl[4]  = '{0, 0, 8'h0B, 8'h11, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h00};
      tbl[5]  = '{1, 0, 8'h00, 8'h11, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h40};
      tbl[6]  = '{0, 0, 8'h0C, 8'h11, 8'h40, 8'h87, 4'b0010, 1, 0, 8'h00};
      tbl[7]  = '{1, 0, 8'h00, 8'h11, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h87};
      tbl[8]  = '{1, 0, 8'h00, 8'h11, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h40};
      tbl[9]  = '{0, 0, 8'h02, 8'h11, 8'h40, 8'h87, 4'b0100, 1, 0, 8'h00};
      tbl[10] = '{0, 0, 8'h0A, 8'h33, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h00};
      tbl[11] = '{1, 0, 8'h00, 8'h33, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h33};
      tbl[12] = '{0, 0, 8'h68, 8'h33, 8'h40, 8'h87, 4'b0000, 1, 1, 8'h00};
      tbl[13] = '{0, 0, 8'h48, 8'h33, 8'h40, 8'h87, 4'b0000, 1, 0, 8'h00};
      tbl[14] = '{1, 1, 8'h00, 8'h33, 8'h40, 8'h87, 4'b0000, 1, 0, 8'hA5};
   end

   initial begin
      logic [3:0] e_stb;
      logic [7:0] e_dout;

      #1;
      rst_n = 1'b0;
      #3;
      chk("reset_regs",
          {icw1_q, icw2_q, icw3_q, icw4_q, imr_q, ocw2_q, ocw3_q, dout},
          64'h0);
      chk("reset_bits",
          {smm_q, init_done, icw1_stb, ocw2_stb, poll_stb,
           bus_err, dout_oe}, 64'h0);
      rst_n = 1'b1;
      tick();
      tick();

      // vector table
      for (int i = 0; i < 15; i++) begin
         irr_in  = tbl[i].irr;
         isr_in  = tbl[i].isr;
         poll_in = tbl[i].poll;
         if (tbl[i].rd) begin
            rd(tbl[i].a);
            chk($sformatf("tbl%0d_dout", i), s_dout, tbl[i].dout);
            chk($sformatf("tbl%0d_oe", i), s_oe, 1'b1);
         end else begin
            wr(tbl[i].a, tbl[i].d);
         end
         chk($sformatf("tbl%0d_stb", i), s_stb, tbl[i].stb);
         chk($sformatf("tbl%0d_init", i), init_done, tbl[i].init);
         chk($sformatf("tbl%0d_smm", i), smm_q, tbl[i].smm);
      end
      chk("tbl_ocw", {ocw2_q, ocw3_q}, 16'h0248);
      chk("oe_low", dout_oe, 1'b0);

      // cascade with ICW4 on both parameter flavours
      do_reset();
      wr(0, 8'h11);
      wr(1, 8'h08);
      chk("casc_mid", init_done, 1'b0);
      wr(1, 8'h04);
      chk("casc_icw3_wait", init_done, 1'b0);
      chk("nc_icw4", {n_icw3, n_icw4, 7'd0, n_init}, 24'h000401);
      wr(1, 8'h01);
      chk("casc_done", init_done, 1'b1);
      chk("casc_regs", {icw1_q, icw2_q, icw3_q, icw4_q}, 32'h11080401);
      chk("nc_imr", n_imr, 8'h01);

      do_reset();
      wr(0, 8'h11);
      wr(1, 8'h08);
      wr(1, 8'h01);
      chk("nc_skip3", {n_icw3, n_icw4, 7'd0, n_init}, 24'h000101);
      chk("casc_icw3", {icw3_q, icw4_q, 7'd0, init_done}, 24'h010000);

      // ICW1 re-issued from READY
      do_reset();
      wr(0, 8'h12);
      wr(1, 8'h20);
      wr(1, 8'hFF);
      chk("imr_ff", imr_q, 8'hFF);
      wr(0, 8'h12);
      chk("reinit_stb", s_stb, 4'b1000);
      chk("reinit_state", {imr_q, 7'd0, init_done}, 16'h0000);

      // wr_n held low for 5 clocks -> single ICW2 write only
      cs_n = 1'b0;
      a0   = 1'b1;
      din  = 8'h55;
      wr_n = 1'b0;
      repeat (5) tick();
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick();
      chk("held_wr", {icw2_q, imr_q, 7'd0, init_done}, 24'h550001);

      // rd_n and wr_n falling together
      cs_n = 1'b0;
      a0   = 1'b1;
      din  = 8'h99;
      wr_n = 1'b0;
      rd_n = 1'b0;
      tick();
      chk("clash_err", {bus_err, dout_oe}, 2'b11);
      wr_n = 1'b1;
      rd_n = 1'b1;
      cs_n = 1'b1;
      tick();
      chk("clash_noreg", {imr_q, dout, 6'd0, bus_err, dout_oe}, 24'h0);

      // async reset in WAIT_ICW3
      do_reset();
      wr(0, 8'h11);
      wr(1, 8'h08);
      chk("pre_rst", icw2_q, 8'h08);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst",
          {icw1_q, icw2_q, 7'd0, init_done}, 24'h0);
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      wr(1, 8'h08);
      chk("idle_err", s_stb, 4'b0001);
      chk("idle_ignored", {icw2_q, 7'd0, init_done}, 16'h0);

      // randomised run against the model
      do_reset();
      m_reset();
      for (int n = 0; n < 400; n++) begin
         int r;
         logic       a;
         logic [7:0] d;
         r = $urandom_range(0, 14);
         if (r < 5) begin
            a       = $urandom_range(0, 1);
            irr_in  = $urandom;
            isr_in  = $urandom;
            poll_in = $urandom;
            e_dout  = m_read(a);
            rd(a);
            chk($sformatf("rnd%0d_dout", n), s_dout, e_dout);
            chk($sformatf("rnd%0d_rstb", n), s_stb, 4'b0000);
         end else begin
            d = $urandom;
            if (r == 5) begin
               a = 0;
               d[4] = 1'b1;
            end else if (r < 10) begin
               a = 1;
            end else begin
               a = 0;
               d[4] = 1'b0;
            end
            m_write(a, d, e_stb);
            wr(a, d);
            chk($sformatf("rnd%0d_stb", n), s_stb, e_stb);
         end
         chk($sformatf("rnd%0d_icw", n),
             {icw1_q, icw2_q, icw3_q, icw4_q},
             {m_icw[1], m_icw[2], m_icw[3], m_icw[4]});
         chk($sformatf("rnd%0d_ocw", n),
             {imr_q, ocw2_q, ocw3_q, smm_q, init_done},
             {m_imr, m_ocw2, m_ocw3, m_smm, m_ready});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
